// File: rtl/core_run_pkg.sv
// Shared types and constants for the program-run sequencer.
// Holds the run state encoding, default widths and counter width.
package core_run_pkg;

   localparam int DEF_AW = 8;
   localparam int DEF_DW = 8;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CORE_RST,
      S_RUN,
      S_DRAIN
   } run_state_t;

endpackage

// File: rtl/run_timeout_ctr.sv
// Saturating run-cycle counter with clear, enable and terminal compare.
// Ports: clk, reset (sync, high), clr, en; count value, at_term flag.
module run_timeout_ctr
   import core_run_pkg::*;
#(
   parameter int TERM = 4095
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             at_term
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign at_term = (count == CNT_W'(TERM));

endmodule

// File: rtl/core_run_sequencer.sv
// Host-side sequencer: load data memory, reset/run the core, drain results.
// Ports: host control/status, load stream, memory port, core, result stream.
module core_run_sequencer
   import core_run_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int RST_CYC = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             host_start,
   input  logic [AW:0]      ld_len,
   input  logic [AW-1:0]    rd_base,
   input  logic [AW:0]      rd_len,
   output logic             host_busy,
   output logic             run_done,
   output logic             timeout_err,
   output logic [CNT_W-1:0] cycle_count,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [DW-1:0]    ld_data,
   output logic             mem_sel,
   output logic             mem_wr_en,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wr_data,
   input  logic [DW-1:0]    mem_rd_data,
   output logic             core_reset,
   output logic             core_req,
   input  logic             core_done,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DW-1:0]    res_data
);

   localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [AW:0] ONE = (AW+1)'(1);

   run_state_t state, state_nx;

   logic [AW:0]   idx;
   logic [AW:0]   ld_len_q;
   logic [AW:0]   rd_len_q;
   logic [AW-1:0] rd_base_q;
   logic [RW-1:0] rcnt;
   logic [AW:0]   ld_last;
   logic [AW:0]   rd_last;

   logic start;
   logic ld_beat;
   logic res_beat;
   logic to_hit;
   logic run_first;
   logic at_term;

   assign ld_last   = ld_len_q - ONE;
   assign rd_last   = rd_len_q - ONE;
   // cycle_count is cleared at start, so zero marks the first RUN cycle
   assign run_first = (cycle_count == '0);

   run_timeout_ctr #(
      .TERM (TIMEOUT - 1)
   ) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .clr     (start),
      .en      (state == S_RUN),
      .count   (cycle_count),
      .at_term (at_term)
   );

   always_comb begin
      state_nx    = state;
      host_busy   = 1'b1;
      run_done    = 1'b0;
      ld_ready    = 1'b0;
      mem_sel     = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      core_reset  = 1'b1;
      core_req    = 1'b0;
      res_valid   = 1'b0;
      res_data    = '0;
      start       = 1'b0;
      ld_beat     = 1'b0;
      res_beat    = 1'b0;
      to_hit      = 1'b0;
      unique case (state)
         S_IDLE: begin
            host_busy = 1'b0;
            if (host_start) begin
               start    = 1'b1;
               state_nx = (ld_len != '0) ? S_LOAD : S_CORE_RST;
            end
         end
         S_LOAD: begin
            mem_sel     = 1'b1;
            ld_ready    = 1'b1;
            mem_addr    = idx[AW-1:0];
            mem_wr_data = ld_data;
            if (ld_valid) begin
               ld_beat   = 1'b1;
               mem_wr_en = 1'b1;
               if (idx == ld_last) state_nx = S_CORE_RST;
            end
         end
         S_CORE_RST: begin
            if (rcnt == RW'(RST_CYC - 1)) state_nx = S_RUN;
         end
         S_RUN: begin
            core_reset = 1'b0;
            core_req   = run_first;
            // done beats the timeout when both land together
            if (core_done && !run_first) begin
               state_nx = S_DRAIN;
            end else if (at_term) begin
               to_hit   = 1'b1;
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            mem_sel   = 1'b1;
            mem_addr  = rd_base_q + idx[AW-1:0];
            res_data  = mem_rd_data;
            res_valid = (rd_len_q != '0);
            if (rd_len_q == '0) begin
               run_done = 1'b1;
               state_nx = S_IDLE;
            end else if (res_ready) begin
               res_beat = 1'b1;
               if (idx == rd_last) begin
                  run_done = 1'b1;
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
      // no write or result beat may complete on a reset edge
      if (reset) begin
         ld_ready  = 1'b0;
         mem_wr_en = 1'b0;
         res_valid = 1'b0;
         run_done  = 1'b0;
         core_req  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         ld_len_q    <= '0;
         rd_len_q    <= '0;
         rd_base_q   <= '0;
         rcnt        <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (start) begin
            ld_len_q    <= ld_len;
            rd_len_q    <= rd_len;
            rd_base_q   <= rd_base;
            idx         <= '0;
            timeout_err <= 1'b0;
         end
         if (ld_beat) begin
            idx <= (state_nx == S_CORE_RST) ? '0 : idx + ONE;
         end
         if (res_beat) idx <= idx + ONE;
         if (state == S_CORE_RST) begin
            rcnt <= (state_nx == S_RUN) ? '0 : rcnt + RW'(1);
         end
         if (to_hit) timeout_err <= 1'b1;
      end
   end

endmodule
